// File: rtl/kb_pkg.sv
// Shared constants for the keyboard FIFO: default depth and the bit layout
// of the CPU-visible status and command registers.
package kb_pkg;

    // Default log2 of the FIFO depth (16 entries).
    localparam int KB_DEPTH_LOG2 = 4;

    // Status register bit positions: {irq_en, ovf, full, count[4:0]}.
    localparam int ST_IRQEN   = 7;
    localparam int ST_OVF     = 6;
    localparam int ST_FULL    = 5;
    localparam int ST_CNT_LSB = 0;
    localparam int ST_CNT_W   = 5;

    // Command register bit positions.
    localparam int CMD_FLUSH  = 0;
    localparam int CMD_CLROVF = 1;
    localparam int CMD_IRQEN  = 7;

    // Fold an occupancy count into the 5-bit status field, saturating at 31
    // so very deep FIFOs never report a wrapped-around small count.
    function automatic logic [ST_CNT_W-1:0] sat_cnt5(input logic [31:0] cnt);
        return (cnt > 32'd31) ? 5'd31 : cnt[ST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/kb_fifo_mem.sv
// Key-byte storage for kb_fifo: synchronous write, asynchronous read.
module kb_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write the incoming key byte into the addressed slot.
    // NOTE: the array has no reset; its contents only matter once the
    // pointers and count (which are reset) say a slot holds a valid byte.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kb_fifo.sv
// Keyboard key-code FIFO between the PS/2 decoder and the CPU I/O space.
// Captures one byte per rising edge of kb_done, exposes the head byte,
// a status register and a command register, and raises a level irq while
// keys are pending and interrupts are enabled.
module kb_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH_LOG2 = KB_DEPTH_LOG2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kb_done,
    input  logic [7:0] kb_data,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wdata,
    output logic [7:0] head,
    output logic [7:0] status,
    output logic       irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic                  done_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_en_q, irq_en_d;

    logic       full, empty;
    logic       push, pop, flush, clr_ovf, overflow;
    logic       wr_en, rd_en;
    logic [7:0] mem_rdata;

    // Bits 6:2 of the command byte carry no meaning.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^io_wdata[6:2];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A held kb_done produces a single push on its rising edge.
    assign push     = kb_done & ~done_q;
    assign pop      = io_rd & ~empty;
    assign flush    = io_wr & io_wdata[CMD_FLUSH];
    assign clr_ovf  = io_wr & io_wdata[CMD_CLROVF];
    assign overflow = push & full & ~pop;

    // A push into a full FIFO only lands when a pop frees a slot the same
    // cycle; a flush discards both the push and the pop.
    assign wr_en = push & (~full | pop) & ~flush;
    assign rd_en = pop & ~flush;

    kb_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (8)
    ) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (kb_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, count and flags.
    // NOTE: every output of this block gets a default first, so no path
    // through the ifs leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Clearing overflow yields to a same-cycle overflow event.
        if (clr_ovf)  ovf_d = 1'b0;
        if (overflow) ovf_d = 1'b1;

        if (io_wr) irq_en_d = io_wdata[CMD_IRQEN];
    end

    // State registers, including the kb_done edge detector.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            done_q   <= kb_done;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
        end
    end

    // CPU-visible head byte and status register.
    always_comb begin
        head   = empty ? 8'h00 : mem_rdata;
        status = 8'h00;
        status[ST_IRQEN] = irq_en_q;
        status[ST_OVF]   = ovf_q;
        status[ST_FULL]  = full;
        status[ST_CNT_LSB +: ST_CNT_W] = sat_cnt5(32'(count_q));
    end

    assign irq = irq_en_q & ~empty;

endmodule

// File: tb/tb_kb_fifo.sv
// Self-checking bench for kb_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_kb_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       kb_done = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       io_rd = 1'b0;
    logic       io_wr = 1'b0;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] head;
    logic [7:0] status;
    logic       irq;

    int checks = 0;
    int errors = 0;

    kb_fifo dut (
        .clock    (clock),
        .reset    (reset),
        .kb_done  (kb_done),
        .kb_data  (kb_data),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_wdata (io_wdata),
        .head     (head),
        .status   (status),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of pending bytes plus the three flags.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_irq_en = 1'b0;
    logic       m_prev_done = 1'b0;

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_irq_en = 1'b0;
        m_prev_done = 1'b0;
    endtask

    // Apply the FIFO rules to the inputs present at a rising clock edge.
    task automatic model_step();
        bit is_push, is_pop, is_flush, ovf_evt;
        is_push  = kb_done && !m_prev_done;
        m_prev_done = kb_done;
        is_flush = io_wr && io_wdata[0];
        is_pop   = io_rd && (q.size() != 0);
        ovf_evt  = is_push && (q.size() == 16) && !is_pop;
        if (io_wr) begin
            m_irq_en = io_wdata[7];
            if (io_wdata[1]) m_ovf = 1'b0;
        end
        if (ovf_evt) m_ovf = 1'b1;
        if (is_flush) begin
            q.delete();
        end else begin
            if (is_pop) void'(q.pop_front());
            if (is_push && !ovf_evt) q.push_back(kb_data);
        end
    endtask

    // Expected {head, status, irq} from the model.
    function automatic logic [16:0] exp_vec();
        int n;
        logic [7:0] h;
        logic [4:0] c5;
        n  = q.size();
        h  = (n != 0) ? q[0] : 8'h00;
        c5 = 5'(n);
        return {h, m_irq_en, m_ovf, (n == 16), c5, (m_irq_en && n != 0)};
    endfunction

    // One clock: edge, model update, settle.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic d, input logic [7:0] dat, input logic rd,
                          input logic wr, input logic [7:0] wd);
        kb_done = d; kb_data = dat; io_rd = rd; io_wr = wr; io_wdata = wd;
    endtask

    // Push a byte with a one-cycle kb_done pulse followed by an idle cycle.
    task automatic push_byte(input logic [7:0] b);
        set_in(1'b1, b, 1'b0, 1'b0, 8'h00);
        cycle();
        set_in(1'b0, b, 1'b0, 1'b0, 8'h00);
        cycle();
    endtask

    task automatic test_reset();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        model_reset();
        #3;
        checks++;
        if ({head, status, irq} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", {head, status, irq}, 17'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        cycle();
        checks++;
        if ({head, status, irq} !== exp_vec()) begin
            errors++;
            $display("FAIL idle_after_reset got %h want %h", {head, status, irq}, exp_vec());
        end
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        cycle();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({head, status, irq} !== 17'h0) begin
            errors++;
            $display("FAIL rd_on_empty got %h want %h", {head, status, irq}, 17'h0);
        end
    endtask

    task automatic test_hold_push();
        set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'h80);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 8'h61, 1'b0, 1'b0, 8'h00);
            cycle();
            checks++;
            if ({head, status, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL hold_push_c%0d got %h want %h", i, {head, status, irq}, exp_vec());
            end
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle();
        checks++;
        if ({head, status, irq} !== {8'h61, 8'h81, 1'b1}) begin
            errors++;
            $display("FAIL hold_push_single got %h want %h", {head, status, irq}, {8'h61, 8'h81, 1'b1});
        end
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        cycle();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({head, status, irq} !== {8'h00, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL hold_push_pop got %h want %h", {head, status, irq}, {8'h00, 8'h80, 1'b0});
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
        push_byte(8'h41);
        checks++;
        if (status !== 8'hF0 || {head, status, irq} !== exp_vec()) begin
            errors++;
            $display("FAIL overflow_status got %h want %h", status, 8'hF0);
        end
        // Drop irq_en so the status reads exactly {ovf, full, 16}.
        set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        cycle();
        checks++;
        if (status !== 8'h70) begin
            errors++;
            $display("FAIL overflow_status_noirq got %h want %h", status, 8'h70);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (head !== 8'h30 + 8'(i) || head !== exp_vec()[16:9]) begin
                errors++;
                $display("FAIL overflow_drain_%0d got %h want %h", i, head, 8'h30 + 8'(i));
            end
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
            cycle();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'h02);
        cycle();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({head, status, irq} !== 17'h0) begin
            errors++;
            $display("FAIL overflow_clear got %h want %h", {head, status, irq}, 17'h0);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
        set_in(1'b1, 8'h0A, 1'b1, 1'b0, 8'h00);
        cycle();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({head, status, irq} !== {8'h31, 8'h30, 1'b0}) begin
            errors++;
            $display("FAIL full_push_pop got %h want %h", {head, status, irq}, {8'h31, 8'h30, 1'b0});
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({head, status, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain_%0d got %h want %h", i, {head, status, irq}, exp_vec());
            end
            if (i == 15) begin
                checks++;
                if (head !== 8'h0A) begin
                    errors++;
                    $display("FAIL full_last_byte got %h want %h", head, 8'h0A);
                end
            end
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
            cycle();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_flush();
        push_byte(8'h11);
        push_byte(8'h12);
        push_byte(8'h13);
        set_in(1'b1, 8'h20, 1'b0, 1'b1, 8'h01);
        cycle();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle();
        checks++;
        if ({head, status, irq} !== 17'h0) begin
            errors++;
            $display("FAIL flush_with_push got %h want %h", {head, status, irq}, 17'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 15) == 0), 8'($urandom));
            // Keep flushes rare so the FIFO regularly fills and overflows.
            if (io_wr && io_wdata[0] && $urandom_range(0, 3) != 0) io_wdata[0] = 1'b0;
            cycle();
            checks++;
            if ({head, status, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL random_c%0d got %h want %h", i, {head, status, irq}, exp_vec());
            end
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle();
    endtask

    task automatic test_mid_reset();
        set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'h01);
        cycle();
        for (int i = 0; i < 17; i++) push_byte(8'h50 + 8'(i));
        for (int i = 0; i < 11; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
            cycle();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (status !== 8'h45 || {head, status, irq} !== exp_vec()) begin
            errors++;
            $display("FAIL mid_reset_setup got %h want %h", status, 8'h45);
        end
        set_in(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({head, status, irq} !== 17'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h want %h", {head, status, irq}, 17'h0);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        cycle();
        checks++;
        if ({head, status, irq} !== {8'h77, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_repush got %h want %h", {head, status, irq}, {8'h77, 8'h01, 1'b0});
        end
        cycle();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({head, status, irq} !== exp_vec() || status !== 8'h01) begin
            errors++;
            $display("FAIL mid_reset_held got %h want %h", {head, status, irq}, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_hold_push();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kb_fifo.md
Name: kb_fifo

Overview:
- Downstream stage of the PS/2 keyboard decoder (`kb`).
- Captures each decoded key byte (kb_done pulse + kb_data) into a small FIFO so keystrokes are not lost while the AVR core is busy.
- Exposes head byte, status and a command register to the CPU I/O space.
- Raises a level interrupt request while keys are pending.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 16 entries.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- kb_done  in  1  key-valid strobe from `kb`; may be held more than one cycle.
- kb_data  in  8  key code from `kb`; valid while kb_done=1.
- io_rd  in  1  CPU read strobe of data port; pops one entry.
- io_wr  in  1  CPU write strobe of command port.
- io_wdata  in  8  command byte. bit0 = flush FIFO; bit1 = clear overflow; bit7 = irq enable value.
- head  out  8  front entry; 8'h00 when empty.
- status  out  8  {irq_en, ovf, full, count[4:0]}.
- irq  out  1  irq_en & (count != 0).

Behaviour:
- Reset (async, reset=1), all of the following apply immediately:
  - rd/wr pointers = 0, count = 0, ovf = 0, irq_en = 0, edge register = 0.
  - Outputs: head = 8'h00, status = 8'h00, irq = 0.
  - Storage contents are don't-care.
- Push detect:
  - push = kb_done & ~done_q; done_q <= kb_done each cycle.
  - A held kb_done yields exactly one push.
  - kb_data is captured in the same cycle as the rising edge.
- Pop: pop = io_rd & (count != 0). io_rd on an empty FIFO is ignored, with no pointer change.
- Latency:
  - A push sampled at edge N is visible in head/count after edge N.
  - A pop at edge N advances head after edge N.
  - head is combinational from storage[rd_ptr], masked to 0 when count = 0.
- Full:
  - push & ~pop & full → byte dropped, ovf <= 1 (sticky), pointers unchanged.
  - push & pop & full → both occur, count stays at depth, ovf unchanged.
- Empty: push & io_rd & empty → push succeeds, pop ignored, count = 1.
- Count: DEPTH_LOG2+1 bits. The status count field is count[4:0], saturating to 31 if depth > 31.
- full = (count == depth). Pointers wrap modulo depth naturally.
- Command write (io_wr=1):
  - irq_en <= io_wdata[7].
  - If bit0 = 1: pointers = 0, count = 0, and any same-cycle push and pop are discarded (flush wins).
  - If bit1 = 1: ovf <= 0. A same-cycle overflow event takes priority, so ovf stays 1.
  - Bits 6:2 are ignored.
- irq:
  - Combinational level, no pulse.
  - CPU clears it by draining the FIFO or clearing irq_en.
- No state machine beyond the FIFO; flow is a pure handshake. Only clock domain is `clock`; ps/2 synchronisation is done upstream.
- Reset mid-operation: asserting reset while kb_done is high clears done_q. If kb_done is still high after reset deasserts, that counts as a rising edge and is pushed once.

Decomposition:
- Package kb_pkg:
  - STATUS bit positions: ST_IRQEN = 7, ST_OVF = 6, ST_FULL = 5, ST_CNT_LSB = 0.
  - Command bit positions: CMD_FLUSH = 0, CMD_CLROVF = 1, CMD_IRQEN = 7.
  - Default DEPTH_LOG2.
- One sub-module, kb_fifo_mem:
  - 2^DEPTH_LOG2 × 8 storage array.
  - Synchronous write on posedge clock, asynchronous read.
  - No reset on the array.
- Pointers, count, flags and the edge detector live in kb_fifo.

Test Plan:
- Reset released, no stimulus → head = 00, status = 00, irq = 0; io_rd ignored, count stays 0.
- Push 8'h61 with kb_done held 3 cycles, irq_en set via io_wr 8'h80 → one entry only; head = 61, status = 8'h81, irq = 1; after io_rd: status = 8'h80, head = 00, irq = 0.
- Push 16 bytes 8'h30..8'h3F, then a 17th byte 8'h41 → status = 8'h70 (ovf, full, count 16); pop all → head sequence 30..3F, 41 never appears; io_wr 8'h02 → ovf = 0.
- FIFO full, push 8'h0A and io_rd in the same cycle → head goes 30→31, count stays 16, ovf = 0, 8'h0A emerges last.
- Three entries queued, io_wr 8'h01 coincident with a push of 8'h20 → count = 0, head = 00, 8'h20 discarded.
- Reset asserted mid-sequence with 5 entries and ovf = 1, kb_done high → outputs 00 immediately; after release, one push of the held kb_data, count = 1.
